// File: rtl/bnn_inference_sequencer.sv
// BNN inference sequencer: per-class XNOR-popcount score over the stored image, argmax reported.
// Define BNN_SCORE_OUT_EN to add best_score / score_margin outputs and second-best tracking.
module bnn_inference_sequencer #(
  parameter int IMG_BITS    = 904,
  parameter int CHUNK_BITS  = 8,
  parameter int NUM_CLASSES = 10,
  localparam int NUM_CHUNKS = (IMG_BITS + CHUNK_BITS - 1) / CHUNK_BITS,
  localparam int SCORE_W    = $clog2(IMG_BITS + 1),
  localparam int CHUNK_AW   = $clog2(NUM_CHUNKS),
  localparam int W_AW       = $clog2(NUM_CLASSES * NUM_CHUNKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  img_ready,
  output logic [CHUNK_AW-1:0]   img_rd_addr,
  input  logic [CHUNK_BITS-1:0] img_rd_data,
  output logic [W_AW-1:0]       w_rd_addr,
  input  logic [CHUNK_BITS-1:0] w_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid,
  output logic [3:0]            result_class
`ifdef BNN_SCORE_OUT_EN
  ,
  output logic [SCORE_W-1:0]    best_score,
  output logic [SCORE_W-1:0]    score_margin
`endif
);

  localparam int REM_BITS = IMG_BITS % CHUNK_BITS;
  localparam logic [CHUNK_BITS-1:0] LAST_MASK = (REM_BITS == 0) ? {CHUNK_BITS{1'b1}}
                                              : CHUNK_BITS'((64'd1 << REM_BITS) - 64'd1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CMP, FINISH} state_t;

  state_t                state_q, state_d;
  logic [CHUNK_AW-1:0]   chunk_q;
  logic [W_AW-1:0]       w_addr_q;
  logic [3:0]            class_q;
  logic [SCORE_W-1:0]    acc_q, best_q;
  logic [3:0]            best_class_q;
  logic [3:0]            res_class_q;
  logic                  res_valid_q;

  logic                  accept, last_chunk, last_class, acc_en, take;
  logic [CHUNK_BITS-1:0] xnor_bits;
  logic [SCORE_W-1:0]    pop;
  logic [3:0]            new_class;

  assign accept     = (state_q == IDLE) && start && img_ready;
  assign last_chunk = (chunk_q == CHUNK_AW'(NUM_CHUNKS - 1));
  assign last_class = (class_q == 4'(NUM_CLASSES - 1));
  // Read data lags the address by one cycle, so RUN with chunk 0 has nothing to add yet.
  assign acc_en     = ((state_q == RUN) && (chunk_q != '0)) || (state_q == DRAIN);
  assign take       = (class_q == '0) || (acc_q > best_q);
  assign new_class  = take ? class_q : best_class_q;

  always_comb begin
    xnor_bits = ~(img_rd_data ^ w_rd_data);
    if (state_q == DRAIN) xnor_bits = xnor_bits & LAST_MASK;
    pop = '0;
    for (int unsigned i = 0; i < CHUNK_BITS; i++) pop = pop + SCORE_W'(xnor_bits[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) state_d = IDLE;
    else begin
      unique case (state_q)
        IDLE:    if (start && img_ready) state_d = RUN;
        RUN:     if (last_chunk) state_d = DRAIN;
        DRAIN:   state_d = CMP;
        CMP:     state_d = last_class ? FINISH : RUN;
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == DRAIN) || (state_q == CMP);
    done = (state_q == FINISH);
  end

  // Result registers load on the CMP->FINISH edge so they are valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunk_q      <= '0;
      w_addr_q     <= '0;
      class_q      <= '0;
      acc_q        <= '0;
      best_q       <= '0;
      best_class_q <= '0;
      res_class_q  <= '0;
      res_valid_q  <= 1'b0;
    end else if (clear) begin
      res_class_q  <= '0;
      res_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          chunk_q      <= '0;
          w_addr_q     <= '0;
          class_q      <= '0;
          acc_q        <= '0;
          best_q       <= '0;
          best_class_q <= '0;
          res_valid_q  <= 1'b0;
        end
        RUN: begin
          if (!last_chunk) begin
            chunk_q  <= chunk_q + CHUNK_AW'(1);
            w_addr_q <= w_addr_q + W_AW'(1);
          end
          if (acc_en) acc_q <= acc_q + pop;
        end
        DRAIN: acc_q <= acc_q + pop;
        CMP: begin
          if (take) begin
            best_q       <= acc_q;
            best_class_q <= class_q;
          end
          acc_q <= '0;
          if (last_class) begin
            res_class_q <= new_class;
            res_valid_q <= 1'b1;
          end else begin
            class_q  <= class_q + 4'd1;
            chunk_q  <= '0;
            w_addr_q <= w_addr_q + W_AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign img_rd_addr  = chunk_q;
  assign w_rd_addr    = w_addr_q;
  assign result_class = res_class_q;
  assign result_valid = res_valid_q;

`ifdef BNN_SCORE_OUT_EN
  logic [SCORE_W-1:0] second_q, new_best, new_second;

  // Displaced best becomes runner-up; class 0 has no predecessor, so runner-up restarts at 0.
  always_comb begin
    new_best   = take ? acc_q : best_q;
    new_second = take ? ((class_q == '0) ? '0 : best_q)
                      : ((acc_q > second_q) ? acc_q : second_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_q     <= '0;
      best_score   <= '0;
      score_margin <= '0;
    end else if (clear) begin
      best_score   <= '0;
      score_margin <= '0;
    end else if (accept) begin
      second_q <= '0;
    end else if (state_q == CMP) begin
      second_q <= new_second;
      if (last_class) begin
        best_score   <= new_best;
        score_margin <= new_best - new_second;
      end
    end
  end
`else
  // Score outputs and runner-up tracking are compiled out.
`endif

endmodule

// File: doc/bnn_inference_sequencer.md
Name: bnn_inference_sequencer

Overview:
Sequences one binary-neural-network classification pass over the stored 904-bit image. Reads the image buffer and a class-weight ROM chunk by chunk, accumulates an XNOR-popcount score per class, and reports the argmax class. Sits between the image buffer (read port) and the BNN result path / top-level FSM (start/done handshake).

Parameters:
IMG_BITS, 904, image size in bits
CHUNK_BITS, 8, bits read per image/weight access
NUM_CLASSES, 10, number of output classes (max 16)
NUM_CHUNKS, ceil(IMG_BITS/CHUNK_BITS) = 113, derived; not to be overridden
SCORE_W, clog2(IMG_BITS+1) = 10, derived score width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a classification pass
clear  in  1  synchronous abort/clear of result
img_ready  in  1  image buffer full; start honoured only when 1
img_rd_addr  out  7  image chunk address (clog2 NUM_CHUNKS)
img_rd_data  in  CHUNK_BITS  image chunk, valid 1 cycle after address
w_rd_addr  out  11  weight address = class*NUM_CHUNKS + chunk
w_rd_data  in  CHUNK_BITS  weight chunk, valid 1 cycle after address
busy  out  1  pass in progress
done  out  1  one-cycle pulse at pass completion
result_valid  out  1  result_class holds a valid result
result_class  out  4  argmax class index

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result_valid=0, result_class=0, img_rd_addr=0, w_rd_addr=0, all counters/accumulators/best score 0.
- States: IDLE, RUN, DRAIN, CMP, FINISH.
- IDLE: start=1 && img_ready=1 && clear=0 -> RUN next cycle; class=0, chunk=0, acc=0, best_score=0, best_class=0; result_valid cleared; busy=1 from the RUN cycle on. start with img_ready=0 is ignored (no latch).
- RUN: each cycle drive img_rd_addr=chunk, w_rd_addr=class*NUM_CHUNKS+chunk; chunk++. Data returned for chunk k-1 is accumulated in the same cycle: acc += popcount(~(img_rd_data ^ w_rd_data)). After issuing chunk NUM_CHUNKS-1 -> DRAIN.
- Last-chunk mask: if IMG_BITS % CHUNK_BITS != 0, bits at index >= IMG_BITS%CHUNK_BITS of the last chunk are excluded from the popcount (always 0 contribution). Default config: no masking.
- DRAIN: accumulate final chunk; -> CMP.
- CMP: if acc > best_score (strict) or class==0: best_score=acc, best_class=class. Ties keep the lower class index. acc=0. If class==NUM_CLASSES-1 -> FINISH, else class++, chunk=0 -> RUN.
- FINISH: result_class=best_class, result_valid=1, done=1 for exactly this cycle, busy=0 -> IDLE.
- Timing (defaults): per class 113 RUN + 1 DRAIN + 1 CMP = 115 cycles; done asserted 1 + 10*115 = 1151 cycles after the start-sampling edge.
- Max score = IMG_BITS (904), fits SCORE_W; no overflow.
- start while busy: ignored; no restart.
- clear=1 in any state: next cycle IDLE, busy=0, result_valid=0, result_class=0, no done pulse. clear has priority over start in the same cycle.
- result_valid/result_class held in IDLE until clear or the next accepted start.
- Addresses are held at their last value in IDLE/DRAIN/CMP/FINISH. Read data is ignored outside the accumulate window.

Optional Feature:
Macro BNN_SCORE_OUT_EN. When defined: extra outputs best_score[SCORE_W-1:0] and score_margin[SCORE_W-1:0]. best_score is the winning score. score_margin is best minus second-highest score, with second-highest tracked in CMP. Both are registered in FINISH, reset 0, and cleared by clear. When undefined: ports and second-best tracking are absent; all other behaviour is identical.

Test Plan:
- All-zero image; weights of class 3 all 0 and all other classes all 1; start -> done at cycle 1151, result_class=3, result_valid=1 (with BNN_SCORE_OUT_EN: best_score=904, margin=904).
- All classes given identical weights -> result_class=0 (tie resolves to lowest index).
- Class 7 differs from the image in 2 bits, class 9 in 1 bit, the rest random -> result_class=9 (best_score=903).
- img_ready=0 with start pulsed -> busy stays 0, no done. Then img_ready=1 with start -> normal pass.
- clear asserted at cycle 500 of a pass -> busy=0 next cycle, no done pulse, result_valid=0. A fresh start then completes normally.
- start re-pulsed mid-pass -> ignored; single done at cycle 1151. Assert rst_n low mid-pass -> all outputs 0 immediately.
